// File: rtl/cond_pkg.sv
// cond_pkg: ARM condition-code encodings and NZCV flag bit positions.
package cond_pkg;
    localparam logic [3:0] EQ = 4'h0;
    localparam logic [3:0] NE = 4'h1;
    localparam logic [3:0] CS = 4'h2;
    localparam logic [3:0] CC = 4'h3;
    localparam logic [3:0] MI = 4'h4;
    localparam logic [3:0] PL = 4'h5;
    localparam logic [3:0] VS = 4'h6;
    localparam logic [3:0] VC = 4'h7;
    localparam logic [3:0] HI = 4'h8;
    localparam logic [3:0] LS = 4'h9;
    localparam logic [3:0] GE = 4'hA;
    localparam logic [3:0] LT = 4'hB;
    localparam logic [3:0] GT = 4'hC;
    localparam logic [3:0] LE = 4'hD;
    localparam logic [3:0] AL = 4'hE;
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;
endpackage

// File: rtl/cond_check.sv
// cond_check: combinational evaluation of an ARM condition field against NZCV.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       ce
);
    logic n, z, c, v;
    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];
    always_comb begin
        ce = 1'b1;
        case (cond)
            EQ: ce = z;
            NE: ce = ~z;
            CS: ce = c;
            CC: ce = ~c;
            MI: ce = n;
            PL: ce = ~n;
            VS: ce = v;
            VC: ce = ~v;
            HI: ce = c & ~z;
            LS: ce = ~c | z;
            GE: ce = n == v;
            LT: ce = n != v;
            GT: ce = ~z & (n == v);
            LE: ce = z | (n != v);
            default: ce = 1'b1;
        endcase
    end
endmodule

// File: rtl/cond_unit.sv
// cond_unit: conditional-execute stage; gates decoder writes on NZCV and owns the flags register.
module cond_unit
    import cond_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    input  logic [1:0]       flag_w,
    input  logic             pcs,
    input  logic             reg_w,
    input  logic             mem_w,
    input  logic             no_write,
    input  logic [3:0]       wa3,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_wa3,
    output logic             pc_src,
    output logic             reg_write,
    output logic             mem_write,
    output logic             cond_ex,
    output logic [3:0]       flags
);
    logic ce, accept;
    cond_check u_check (.cond(cond), .flags(flags), .ce(ce));
    assign in_ready = (~out_valid | out_ready) & ~flush;
    assign accept = in_valid & in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_wa3    <= '0;
            pc_src     <= 1'b0;
            reg_write  <= 1'b0;
            mem_write  <= 1'b0;
            cond_ex    <= 1'b0;
            flags      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= alu_result;
            out_wa3    <= wa3;
            pc_src     <= pcs & ce;
            reg_write  <= reg_w & ce & ~no_write;
            mem_write  <= mem_w & ce;
            cond_ex    <= ce;
            if (ce && flag_w[1]) flags[N_BIT:Z_BIT] <= alu_flags[N_BIT:Z_BIT];
            if (ce && flag_w[0]) flags[C_BIT:V_BIT] <= alu_flags[C_BIT:V_BIT];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule
